// File: rtl/i2c_pkg.sv
// Shared types for the multi-byte I2C master: FSM state encodings,
// R/W bit values and the quarter-phase enumeration of one SCL bit.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_START    = 4'd1,
        ST_ADDR     = 4'd2,
        ST_ACK_ADDR = 4'd3,
        ST_WRITE    = 4'd4,
        ST_ACK_WR   = 4'd5,
        ST_READ     = 4'd6,
        ST_ACK_RD   = 4'd7,
        ST_STOP     = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } q_phase_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_quarter_timer.sv
// SCL quarter-period timer: divides clk by CLK_DIV and walks Q0..Q3.
// Ports: clk, reset, run (enable), scl_in (synchronised SCL),
//        tick (end-of-quarter pulse), phase (current quarter).
module i2c_quarter_timer
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     run,
    input  logic     scl_in,
    output logic     tick,
    output q_phase_t phase
);

    localparam int DW = $clog2(CLK_DIV);

    logic [DW-1:0] cnt;
    logic          at_end;
    logic          stretch;

    assign at_end  = (cnt == DW'(CLK_DIV - 1));
    // Slave holds SCL low after we released it: freeze at the end of Q2.
    assign stretch = (phase == Q2) && !scl_in;
    assign tick    = run && at_end && !stretch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            phase <= Q0;
        end else if (!run) begin
            cnt   <= '0;
            phase <= Q0;
        end else if (tick) begin
            cnt   <= '0;
            phase <= q_phase_t'(phase + 2'd1);
        end else if (!at_end) begin
            cnt   <= cnt + DW'(1);
        end
    end

endmodule

// File: rtl/i2c_master_multibyte.sv
// Multi-byte I2C master: START, address+R/W, 0..MAX_BYTES data bytes, STOP.
// Ports: start/rw/periph_addr/num_bytes request, tx_data/tx_ready and
//        rx_data/rx_valid byte streams, busy/done/nack status, state
//        debug, open-drain scl/sda pins.
module i2c_master_multibyte
    import i2c_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int MAX_BYTES = 15,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             rw,
    input  logic [6:0]       periph_addr,
    input  logic [CNT_W-1:0] num_bytes,
    input  logic [7:0]       tx_data,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic             nack,
    output logic [3:0]       state,
    inout  wire              scl,
    inout  wire              sda
);

    state_t           st;
    q_phase_t         phase;
    logic             tick;
    logic             scl_low, sda_low;
    logic             scl_meta, scl_sync;
    logic             sda_meta, sda_sync;
    logic [7:0]       sh;
    logic [2:0]       bit_cnt;
    logic [CNT_W-1:0] rem;
    logic             rw_q;
    logic             ack_bit;
    logic             end_q0, end_q1, end_q2, end_q3;

    assign scl   = scl_low ? 1'b0 : 1'bz;
    assign sda   = sda_low ? 1'b0 : 1'bz;
    assign state = st;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_meta <= 1'b1;
            scl_sync <= 1'b1;
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
        end else begin
            scl_meta <= scl;
            scl_sync <= scl_meta;
            sda_meta <= sda;
            sda_sync <= sda_meta;
        end
    end

    i2c_quarter_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .run    (st != ST_IDLE),
        .scl_in (scl_sync),
        .tick   (tick),
        .phase  (phase)
    );

    // end_qN marks the tick that closes quarter N (entry to N+1).
    assign end_q0 = tick && (phase == Q0);
    assign end_q1 = tick && (phase == Q1);
    assign end_q2 = tick && (phase == Q2);
    assign end_q3 = tick && (phase == Q3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st       <= ST_IDLE;
            scl_low  <= 1'b0;
            sda_low  <= 1'b0;
            sh       <= '0;
            bit_cnt  <= '0;
            rem      <= '0;
            rw_q     <= RW_WRITE;
            ack_bit  <= 1'b0;
            tx_ready <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            nack     <= 1'b0;
        end else begin
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            done     <= 1'b0;
            if (end_q1) scl_low <= 1'b0;
            unique case (st)
                ST_IDLE: begin
                    if (start) begin
                        rw_q    <= rw;
                        sh      <= {periph_addr, rw};
                        rem     <= (num_bytes > CNT_W'(MAX_BYTES))
                                   ? CNT_W'(MAX_BYTES) : num_bytes;
                        nack    <= 1'b0;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                        st      <= ST_START;
                    end
                end
                ST_START: begin
                    // SDA falls in Q1 while SCL is still released.
                    if (end_q0) sda_low <= 1'b1;
                    if (end_q3) begin
                        scl_low <= 1'b1;
                        sda_low <= ~sh[7];
                        sh      <= {sh[6:0], 1'b0};
                        st      <= ST_ADDR;
                    end
                end
                ST_ADDR, ST_WRITE: begin
                    // First data bit goes out one clk into Q0.
                    if (tx_ready) begin
                        sda_low <= ~tx_data[7];
                        sh      <= {tx_data[6:0], 1'b0};
                    end
                    if (end_q3) begin
                        scl_low <= 1'b1;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            sda_low <= 1'b0;
                            st      <= (st == ST_ADDR)
                                       ? ST_ACK_ADDR : ST_ACK_WR;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            sda_low <= ~sh[7];
                            sh      <= {sh[6:0], 1'b0};
                        end
                    end
                end
                ST_ACK_ADDR: begin
                    if (end_q2) ack_bit <= sda_sync;
                    if (end_q3) begin
                        scl_low <= 1'b1;
                        if (ack_bit) begin
                            nack    <= 1'b1;
                            sda_low <= 1'b1;
                            st      <= ST_STOP;
                        end else if (rem == '0) begin
                            sda_low <= 1'b1;
                            st      <= ST_STOP;
                        end else if (rw_q == RW_WRITE) begin
                            tx_ready <= 1'b1;
                            st       <= ST_WRITE;
                        end else begin
                            st <= ST_READ;
                        end
                    end
                end
                ST_ACK_WR: begin
                    if (end_q2) ack_bit <= sda_sync;
                    if (end_q3) begin
                        scl_low <= 1'b1;
                        if (ack_bit) begin
                            nack    <= 1'b1;
                            sda_low <= 1'b1;
                            st      <= ST_STOP;
                        end else begin
                            if (rem != '0) rem <= rem - CNT_W'(1);
                            if (rem <= CNT_W'(1)) begin
                                sda_low <= 1'b1;
                                st      <= ST_STOP;
                            end else begin
                                tx_ready <= 1'b1;
                                st       <= ST_WRITE;
                            end
                        end
                    end
                end
                ST_READ: begin
                    if (end_q2) begin
                        sh <= {sh[6:0], sda_sync};
                        if (bit_cnt == 3'd7) begin
                            rx_data  <= {sh[6:0], sda_sync};
                            rx_valid <= 1'b1;
                        end
                    end
                    if (end_q3) begin
                        scl_low <= 1'b1;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            // ACK while more bytes follow, NACK the last.
                            sda_low <= (rem > CNT_W'(1));
                            st      <= ST_ACK_RD;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                ST_ACK_RD: begin
                    if (end_q3) begin
                        scl_low <= 1'b1;
                        if (rem != '0) rem <= rem - CNT_W'(1);
                        if (rem <= CNT_W'(1)) begin
                            sda_low <= 1'b1;
                            st      <= ST_STOP;
                        end else begin
                            sda_low <= 1'b0;
                            st      <= ST_READ;
                        end
                    end
                end
                ST_STOP: begin
                    // SCL released at Q2; SDA rises at the end of Q3.
                    if (end_q3) begin
                        sda_low <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        st      <= ST_IDLE;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_multibyte.sv
// Scoreboard bench for i2c_master_multibyte with a behavioural slave.
// Stimulus pushes expected bus bytes, rx bytes and done records.
module tb_i2c_master_multibyte;
    import i2c_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] periph_addr = '0;
    logic [3:0] num_bytes = '0;
    logic [7:0] tx_data = '0;
    logic       tx_ready, rx_valid, busy, done, nack;
    logic [7:0] rx_data;
    logic [3:0] state;
    wire        scl, sda;
    logic       slv_scl_low = 1'b0;
    logic       slv_sda_low = 1'b0;

    assign scl = slv_scl_low ? 1'b0 : 1'bz;
    assign sda = slv_sda_low ? 1'b0 : 1'bz;
    pullup (scl);
    pullup (sda);

    always #5 clk = ~clk;

    i2c_master_multibyte #(
        .CLK_DIV   (4),
        .MAX_BYTES (15),
        .CNT_W     (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .rw          (rw),
        .periph_addr (periph_addr),
        .num_bytes   (num_bytes),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .busy        (busy),
        .done        (done),
        .nack        (nack),
        .state       (state),
        .scl         (scl),
        .sda         (sda)
    );

    typedef struct packed {
        logic       nk;
        logic [7:0] tx;
        logic [7:0] rx;
    } done_t;

    int         n_tests = 0;
    int         n_fail = 0;
    int         done_seen = 0;
    int         tx_seen = 0;
    logic [8:0] exp_bus[$];
    logic [7:0] exp_rx[$];
    done_t      exp_done[$];
    logic [7:0] tx_q[$];
    logic [7:0] rd_q[$];
    logic       addr_nack = 1'b0;
    logic       stretch_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Slave, scoreboard monitor and tx_data supplier.
    initial begin : monitor
        logic       ps, pd, s, d;
        logic [7:0] sh, cur;
        logic       in_addr, rd_active, hold_bad, tx_pend, sda_ref;
        logic [3:0] st_ref;
        int         bidx, hold, tx_cnt, rx_cnt, stop_cnt;
        done_t      e;
        ps = 1'b1; pd = 1'b1; sh = '0; cur = '0;
        in_addr = 1'b0; rd_active = 1'b0; hold_bad = 1'b0;
        tx_pend = 1'b0; sda_ref = 1'b1; st_ref = '0;
        bidx = 0; hold = 0; tx_cnt = 0; rx_cnt = 0; stop_cnt = 0;
        forever begin
            @(negedge clk);
            s = scl;
            d = sda;
            if (reset) begin
                slv_scl_low = 1'b0; slv_sda_low = 1'b0;
                in_addr = 1'b0; rd_active = 1'b0; bidx = 0; hold = 0;
                tx_pend = 1'b0; tx_cnt = 0; rx_cnt = 0; stop_cnt = 0;
                ps = s; pd = d;
                continue;
            end
            if (hold > 0) begin
                if (d !== sda_ref || state !== st_ref) hold_bad = 1'b1;
                hold--;
                if (hold == 0) begin
                    slv_scl_low = 1'b0;
                    chk("stretch_hold", 32'(hold_bad), 32'd0);
                end
            end
            if (ps && s && pd && !d) begin
                bidx = 0; in_addr = 1'b1; rd_active = 1'b0;
                slv_sda_low = 1'b0;
            end else if (ps && s && !pd && d) begin
                stop_cnt++; bidx = 0; in_addr = 1'b0;
                rd_active = 1'b0; slv_sda_low = 1'b0;
            end else if (!ps && s) begin
                if (bidx < 8) begin
                    sh = {sh[6:0], d};
                end else begin
                    if (exp_bus.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL bus_byte: got %0h, expected none",
                                 {sh, d});
                    end else begin
                        chk("bus_byte", 32'({sh, d}),
                            32'(exp_bus.pop_front()));
                    end
                    if (in_addr) rd_active = sh[0] && !d;
                    else if (d) rd_active = 1'b0;
                    in_addr = 1'b0;
                end
                bidx = (bidx == 8) ? 0 : bidx + 1;
            end else if (ps && !s) begin
                if (bidx == 8) begin
                    slv_sda_low = in_addr ? !addr_nack : !rd_active;
                end else if (rd_active) begin
                    if (bidx == 0)
                        cur = (rd_q.size() != 0) ? rd_q.pop_front() : 8'hFF;
                    slv_sda_low = !cur[7-bidx];
                end else begin
                    slv_sda_low = 1'b0;
                end
                if (stretch_en && in_addr && bidx == 3) begin
                    stretch_en = 1'b0; slv_scl_low = 1'b1; hold = 20;
                    sda_ref = d; st_ref = state; hold_bad = 1'b0;
                end
            end
            ps = s;
            pd = d;
            if (tx_pend) begin
                tx_pend = 1'b0;
                if (tx_q.size() != 0) void'(tx_q.pop_front());
                tx_data = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
            end
            if (tx_ready) begin
                tx_cnt++; tx_seen++; tx_pend = 1'b1;
            end
            if (rx_valid) begin
                rx_cnt++;
                if (exp_rx.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL rx_data: got %0h, expected none",
                             rx_data);
                end else begin
                    chk("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
                end
            end
            if (done) begin
                done_seen++;
                if (exp_done.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL done: got pulse, expected none");
                end else begin
                    e = exp_done.pop_front();
                    chk("done_nack", 32'(nack), 32'(e.nk));
                    chk("tx_ready_pulses", tx_cnt, 32'(e.tx));
                    chk("rx_valid_pulses", rx_cnt, 32'(e.rx));
                    chk("stop_count", stop_cnt, 32'd1);
                    chk("bus_bytes_left", exp_bus.size(), 32'd0);
                end
                tx_cnt = 0; rx_cnt = 0; stop_cnt = 0;
            end
        end
    end

    task automatic go(input logic r, input logic [6:0] a,
                      input logic [3:0] n);
        @(negedge clk);
        rw = r; periph_addr = a; num_bytes = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int d0;
        int k;
        d0 = done_seen;
        k = 0;
        while (done_seen == d0 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk({"done_", name}, 32'(done_seen != d0), 32'd1);
    endtask

    task automatic load_tx(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input int n);
        tx_q.delete();
        if (n > 0) tx_q.push_back(b0);
        if (n > 1) tx_q.push_back(b1);
        if (n > 2) tx_q.push_back(b2);
        tx_data = (n > 0) ? b0 : 8'h00;
    endtask

    initial begin : stim
        int k;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_nack", 32'(nack), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_scl", 32'(scl), 32'd1);
        chk("rst_sda", 32'(sda), 32'd1);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Write 0x50, two bytes.
        load_tx(8'hA5, 8'h3C, 8'h00, 2);
        exp_bus.push_back({8'hA0, 1'b0});
        exp_bus.push_back({8'hA5, 1'b0});
        exp_bus.push_back({8'h3C, 1'b0});
        exp_done.push_back('{1'b0, 8'd2, 8'd0});
        go(1'b0, 7'h50, 4'd2);
        chk("busy_after_start", 32'(busy), 32'd1);
        wait_done("write2");
        @(negedge clk);
        chk("busy_after_done", 32'(busy), 32'd0);

        // Read 0x48, three bytes: ACK, ACK, NACK from the master.
        rd_q = '{8'h11, 8'h22, 8'h33};
        exp_bus.push_back({8'h91, 1'b0});
        exp_bus.push_back({8'h11, 1'b0});
        exp_bus.push_back({8'h22, 1'b0});
        exp_bus.push_back({8'h33, 1'b1});
        exp_rx.push_back(8'h11);
        exp_rx.push_back(8'h22);
        exp_rx.push_back(8'h33);
        exp_done.push_back('{1'b0, 8'd0, 8'd3});
        go(1'b1, 7'h48, 4'd3);
        wait_done("read3");

        // Address NACK on 0x2A.
        addr_nack = 1'b1;
        load_tx(8'h99, 8'h00, 8'h00, 1);
        exp_bus.push_back({8'h54, 1'b1});
        exp_done.push_back('{1'b1, 8'd0, 8'd0});
        go(1'b0, 7'h2A, 4'd2);
        wait_done("addr_nack");
        addr_nack = 1'b0;
        repeat (5) @(negedge clk);
        chk("nack_sticky", 32'(nack), 32'd1);

        // Clock stretch after the third address bit.
        stretch_en = 1'b1;
        load_tx(8'h5A, 8'h00, 8'h00, 1);
        exp_bus.push_back({8'h66, 1'b0});
        exp_bus.push_back({8'h5A, 1'b0});
        exp_done.push_back('{1'b0, 8'd1, 8'd0});
        go(1'b0, 7'h33, 4'd1);
        chk("nack_cleared", 32'(nack), 32'd0);
        wait_done("stretch");

        // Reset during the second data byte.
        load_tx(8'h01, 8'h02, 8'h03, 3);
        exp_bus.push_back({8'hA0, 1'b0});
        exp_bus.push_back({8'h01, 1'b0});
        exp_bus.push_back({8'h02, 1'b0});
        exp_bus.push_back({8'h03, 1'b0});
        exp_done.push_back('{1'b0, 8'd3, 8'd0});
        k = tx_seen;
        go(1'b0, 7'h50, 4'd3);
        begin
            int w;
            w = 0;
            while (tx_seen < k + 2 && w < 5000) begin
                @(negedge clk);
                w++;
            end
            chk("second_tx_ready", 32'(tx_seen >= k + 2), 32'd1);
        end
        repeat (40) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_bus.delete();
        exp_done.delete();
        tx_q.delete();
        tx_data = 8'h00;
        @(negedge clk);
        chk("midrst_scl", 32'(scl), 32'd1);
        chk("midrst_sda", 32'(sda), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_state", 32'(state), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        load_tx(8'h77, 8'h00, 8'h00, 1);
        exp_bus.push_back({8'h20, 1'b0});
        exp_bus.push_back({8'h77, 1'b0});
        exp_done.push_back('{1'b0, 8'd1, 8'd0});
        go(1'b0, 7'h10, 4'd1);
        wait_done("after_reset");

        // Address-only probe; a start while busy must be ignored.
        load_tx(8'h00, 8'h00, 8'h00, 0);
        exp_bus.push_back({8'hD0, 1'b0});
        exp_done.push_back('{1'b0, 8'd0, 8'd0});
        go(1'b0, 7'h68, 4'd0);
        repeat (100) @(negedge clk);
        chk("probe_busy", 32'(busy), 32'd1);
        go(1'b1, 7'h11, 4'd1);
        wait_done("probe");
        repeat (60) @(negedge clk);
        chk("probe_idle_busy", 32'(busy), 32'd0);
        chk("probe_idle_state", 32'(state), 32'd0);
        chk("probe_nack", 32'(nack), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
